// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the unsigned 32x32 multiplier.
//   MUL_W / PROD_W   : default operand and product widths
//   operand_t        : one multiplier operand
//   product_t        : full double-width product
//   next_rows()      : rows left after one layer of 3:2 compression
//   tree_levels()    : number of 3:2 layers needed to reach two rows
//   rows_at()        : row count entering a given layer
//   row_base()       : start index of a layer in the flattened row array
package mul_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;

  typedef logic [MUL_W-1:0]  operand_t;
  typedef logic [PROD_W-1:0] product_t;

  // Every full group of three rows becomes two; leftover rows pass through.
  function automatic int next_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int tree_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int k = 0; k < lvl; k++) begin
      n = next_rows(n);
    end
    return n;
  endfunction

  // All layers are packed back to back in one array, so a layer's first
  // row sits after every row of the layers before it.
  function automatic int row_base(input int n0, input int lvl);
    int b;
    b = 0;
    for (int k = 0; k < lvl; k++) begin
      b += rows_at(n0, k);
    end
    return b;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 carry-save compressor (a row of full adders).
//   in_a, in_b, in_c : three addend rows, W bits each
//   sum_o            : bitwise sum, same weight as the inputs
//   carry_o          : majority bits, already shifted up one position
// in_a + in_b + in_c == sum_o + carry_o (mod 2^W). The carry out of the top
// bit is dropped; the multiplier's product always fits in W bits, so
// arithmetic modulo 2^W stays exact.
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = in_a ^ in_b ^ in_c;
  assign carry_o = {(in_a[W-2:0] & in_b[W-2:0]) |
                    (in_a[W-2:0] & in_c[W-2:0]) |
                    (in_b[W-2:0] & in_c[W-2:0]), 1'b0};

endmodule

// File: rtl/multiplier_32x32.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiplier for the execute stage.
//   clk_i     : clock, only used when OUT_REG=1
//   rst_ni    : asynchronous active-low reset, only used when OUT_REG=1
//   operand_a : multiplicand, unsigned
//   operand_b : multiplier, unsigned
//   P         : full product operand_a * operand_b
// Structure: AND partial-product array, Wallace-style tree of 3:2
// compressors, and one final carry-propagate adder. With OUT_REG=0 the
// whole path is combinational; with OUT_REG=1 the product is registered.
module multiplier_32x32
  import mul_pkg::*;
#(
  parameter int WIDTH   = MUL_W,
  parameter bit OUT_REG = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH-1:0] P
);

  localparam int PW     = 2 * WIDTH;
  localparam int NLVL   = tree_levels(WIDTH);
  localparam int FINAL  = row_base(WIDTH, NLVL);
  localparam int TOTAL  = FINAL + 2;

  // Rows of every tree layer, flattened: layer 0 holds the partial
  // products, the last two entries feed the final adder.
  logic [PW-1:0] rows [TOTAL];
  logic [PW-1:0] prod;

  // Partial products: operand_a gated by one multiplier bit, placed at
  // that bit's weight.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign rows[i] = {{WIDTH{1'b0}}, operand_a & {WIDTH{operand_b[i]}}} << i;
  end

  // Reduction tree: each layer compresses groups of three rows into two,
  // forwarding up to two leftover rows unchanged to the next layer.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N  = rows_at(WIDTH, l);
    localparam int IB = row_base(WIDTH, l);
    localparam int OB = row_base(WIDTH, l + 1);
    localparam int G  = N / 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(
        .W (PW)
      ) u_csa (
        .in_a    (rows[IB + 3*g]),
        .in_b    (rows[IB + 3*g + 1]),
        .in_c    (rows[IB + 3*g + 2]),
        .sum_o   (rows[OB + 2*g]),
        .carry_o (rows[OB + 2*g + 1])
      );
    end

    for (genvar r = 0; r < N % 3; r++) begin : g_pass
      assign rows[OB + 2*G + r] = rows[IB + 3*G + r];
    end
  end

  // Final carry-propagate adder merges the carry-save pair.
  assign prod = rows[FINAL] + rows[FINAL + 1];

  if (OUT_REG) begin : g_reg
    logic [PW-1:0] p_d;
    logic [PW-1:0] p_q;

    always_comb begin
      p_d = prod;
    end

    // Reset clears the product at once and drops any in-flight result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        p_q <= '0;
      end else begin
        p_q <= p_d;
      end
    end

    assign P = p_q;
  end else begin : g_comb
    // Clock and reset have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign P = prod;
  end

endmodule

// File: tb/tb_multiplier_32x32.sv
module tb_multiplier_32x32;
  import mul_pkg::*;

  logic     clk;
  logic     rst_n;
  operand_t a0, b0, a1, b1;
  product_t p0, p1;

  int checks;
  int errors;

  multiplier_32x32 #(
    .WIDTH   (32),
    .OUT_REG (1'b0)
  ) dut_comb (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .operand_a (a0),
    .operand_b (b0),
    .P         (p0)
  );

  multiplier_32x32 #(
    .WIDTH   (32),
    .OUT_REG (1'b1)
  ) dut_reg (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .operand_a (a1),
    .operand_b (b1),
    .P         (p1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input product_t obs, input product_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic comb_vec(input string tag, input operand_t a, input operand_t b,
                          input product_t exp);
    a0 = a;
    b0 = b;
    #1;
    check(tag, p0, exp);
  endtask

  initial begin
    product_t ref_p;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a0 = '0; b0 = '0;
    a1 = 32'd3; b1 = 32'd5;

    // Registered build holds zero while reset is low, even across edges.
    @(posedge clk);
    #1;
    check("reg_reset_state", p1, 64'h0);

    // Combinational directed vectors.
    comb_vec("zero_a",     32'h00000000, 32'hDEADBEEF, 64'h0000000000000000);
    comb_vec("zero_b",     32'h12345678, 32'h00000000, 64'h0000000000000000);
    comb_vec("identity",   32'h00000001, 32'h89ABCDEF, 64'h0000000089ABCDEF);
    comb_vec("max_max",    32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    comb_vec("msb_msb",    32'h80000000, 32'h80000000, 64'h4000000000000000);
    comb_vec("carry_x2",   32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE);
    comb_vec("carry_2p16", 32'h00010000, 32'h00010000, 64'h0000000100000000);
    comb_vec("small",      32'h00000003, 32'h00000005, 64'h000000000000000F);
    comb_vec("mixed",      32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080);

    // Random regression against a behavioural reference product.
    for (int i = 0; i < 1000; i++) begin
      a0 = $random;
      b0 = $random;
      ref_p = {32'h0, a0} * {32'h0, b0};
      #1;
      check("random", p0, ref_p);
      #49;
    end

    // Registered build: release reset away from the clock edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reg_idle_after_release", p1, 64'h0);
    @(posedge clk);
    #1;
    check("reg_first_edge", p1, 64'd15);

    @(negedge clk);
    a1 = 32'hFFFFFFFF;
    b1 = 32'hFFFFFFFF;
    #1;
    check("reg_holds_until_edge", p1, 64'd15);
    @(posedge clk);
    #1;
    check("reg_max", p1, 64'hFFFFFFFE00000001);

    // Asynchronous reset mid-cycle discards the in-flight product.
    @(negedge clk);
    a1 = 32'd7;
    b1 = 32'd9;
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_reset", p1, 64'h0);
    @(posedge clk);
    #1;
    check("reg_reset_holds", p1, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reg_after_release", p1, 64'd63);

    if (errors != 0) $display("TEST FAILED");
    else             $display("TEST PASSED");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_32x32.md
Name: multiplier_32x32

Overview:
Unsigned 32x32 -> 64-bit integer multiplier for the RV32I/M execute stage. It produces the full double-width product of two operands. In the default configuration it is purely combinational, so the product is valid in the same cycle the operands are applied. An optional output register stage is selected by parameter.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.
- OUT_REG, 0, output mode: 0 = combinational product (clock and reset unused); 1 = product registered on clk_i.

Ports:
- clk_i  input  1  system clock; used only when OUT_REG=1.
- rst_ni  input  1  asynchronous active-low reset; used only when OUT_REG=1.
- operand_a  input  WIDTH  multiplicand, unsigned.
- operand_b  input  WIDTH  multiplier, unsigned.
- P  output  2*WIDTH  product operand_a * operand_b, unsigned.

Behaviour:
- Clocking and reset: one clock (clk_i). Reset rst_ni is asynchronous and active-low.
- Arithmetic:
  - P = zero_extend(operand_a) * zero_extend(operand_b), computed exactly over 2*WIDTH bits.
  - No truncation and no overflow is possible: the maximum product (2^32-1)^2 = 0xFFFF_FFFE_0000_0001 fits in 64 bits.
  - Both operands are always treated as unsigned. Signed MULH/MULHSU variants are handled outside this block by operand and result correction.
- OUT_REG=0:
  - Zero-latency combinational path; P settles within the same delta/cycle.
  - No internal state; P has no reset value and always reflects the current inputs.
  - P must be settled within 1 ns in RTL simulation, i.e. zero-delay RTL.
  - Any X on an operand may propagate X to P.
- OUT_REG=1:
  - P is registered on the rising edge of clk_i, so latency is 1 cycle.
  - rst_ni low asserts P = 0 immediately, regardless of the clock.
  - Deassertion is synchronised externally.
  - If reset asserts while an operation is in flight, that product is discarded.
  - In the first edge after reset release, P captures the current operands.
- Structure:
  - Radix-4 Booth or plain AND partial-product array.
  - Carry-save (Wallace/Dadda) reduction tree, followed by a final 64-bit carry-propagate adder.
  - A behavioural "*" is acceptable as a golden model only, not in the RTL.
- Boundary results:
  - Either operand 0 -> P = 0.
  - Operand 1 -> P = the other operand, zero-extended.
  - All-ones x all-ones -> 0xFFFFFFFE00000001.

Decomposition:
- Package mul_pkg:
  - localparams MUL_W = 32 and PROD_W = 64.
  - typedefs operand_t = logic [MUL_W-1:0] and product_t = logic [PROD_W-1:0].
- One sub-module: csa_3to2 (bitwise full-adder compressor, parameterised width), instantiated repeatedly in the reduction tree.
- The partial-product generation and the final adder stay in multiplier_32x32.

Test Plan:
- Zero: a=0x00000000, b=0xDEADBEEF -> P=0x0000000000000000. Also a=0x12345678, b=0 -> P=0.
- Identity: a=0x00000001, b=0x89ABCDEF -> P=0x0000000089ABCDEF.
- Max: a=0xFFFFFFFF, b=0xFFFFFFFF -> P=0xFFFFFFFE00000001. Also a=0x80000000, b=0x80000000 -> P=0x4000000000000000 (unsigned, no sign interpretation).
- Carry chain: a=0xFFFFFFFF, b=0x00000002 -> P=0x00000001FFFFFFFE. Also a=0x00010000, b=0x00010000 -> P=0x0000000100000000.
- Random regression: 1000 $random operand pairs, checked 1 ns after each update (50 ns apart) against a 64-bit unsigned reference product. Every compare must match; on any mismatch print "TEST FAILED", otherwise report "TEST PASSED".
- OUT_REG=1:
  - Apply a=3, b=5 -> P=15 one rising edge later.
  - Assert rst_ni=0 mid-cycle -> P=0 immediately (asynchronous reset).
  - After release, the next edge loads the current product.
